// File: rtl/prog_loader.sv
// Program loader: assembles a byte stream into instruction words, writes them to
// memory from address 0, and releases the CPU once the declared length is loaded.
module prog_loader #(
    parameter int unsigned INSTR_SIZE   = 16,
    parameter int unsigned ADDR_SIZE    = 5,
    parameter int unsigned PROGRAM_SIZE = 16,
    parameter int unsigned BYTE_W       = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [BYTE_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          wr_en,
    output logic [ADDR_SIZE-1:0]          wr_addr,
    output logic [INSTR_SIZE-1:0]         wr_data,
    output logic                          cpu_run,
    output logic                          done,
    output logic                          err,
    output logic [$clog2(PROGRAM_SIZE):0] words_loaded
);

    localparam int unsigned NB    = (INSTR_SIZE + BYTE_W - 1) / BYTE_W;
    localparam int unsigned ASM_W = NB * BYTE_W;
    localparam int unsigned BC_W  = $clog2(NB + 1);
    localparam int unsigned CNT_W = $clog2(PROGRAM_SIZE) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_WRITE,
        S_RUN,
        S_ERROR
    } state_t;

    state_t                state_q, state_d;
    logic [BC_W-1:0]       bcnt_q, bcnt_d;
    logic [ASM_W-1:0]      asm_q, asm_d;
    logic [CNT_W-1:0]      len_q, len_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;
    logic                  in_ready_q, in_ready_d;
    logic                  wr_en_q, wr_en_d;
    logic                  cpu_run_q, cpu_run_d;
    logic [ADDR_SIZE-1:0]  wr_addr_q, wr_addr_d;
    logic [INSTR_SIZE-1:0] wr_data_q, wr_data_d;

    logic                  xfer_c;
    logic                  last_byte_c;
    logic [ASM_W-1:0]      asm_shift_c;
    logic [INSTR_SIZE-1:0] word_c;

    // New byte enters at the LSB end; bits pushed past ASM_W are dropped.
    assign xfer_c      = in_valid && in_ready_q;
    assign last_byte_c = (bcnt_q == BC_W'(NB - 1));
    assign asm_shift_c = ASM_W'({asm_q, in_data});
    assign word_c      = asm_shift_c[INSTR_SIZE-1:0];

    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        asm_d     = asm_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        done_d    = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (abort) begin
            state_d = S_IDLE;
            bcnt_d  = '0;
            asm_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_RUN, S_ERROR: begin
                    if (start) begin
                        state_d = S_HDR;
                        err_d   = 1'b0;
                        cnt_d   = '0;
                        bcnt_d  = '0;
                        asm_d   = '0;
                    end
                end
                S_HDR: begin
                    if (xfer_c) begin
                        asm_d = asm_shift_c;
                        if (last_byte_c) begin
                            bcnt_d = '0;
                            if (word_c == '0 || word_c > INSTR_SIZE'(PROGRAM_SIZE)) begin
                                state_d = S_ERROR;
                                err_d   = 1'b1;
                            end else begin
                                len_d   = CNT_W'(word_c);
                                state_d = S_LOAD;
                            end
                        end else begin
                            bcnt_d = bcnt_q + BC_W'(1);
                        end
                    end
                end
                S_LOAD: begin
                    if (xfer_c) begin
                        asm_d = asm_shift_c;
                        if (last_byte_c) begin
                            bcnt_d    = '0;
                            wr_data_d = word_c;
                            wr_addr_d = ADDR_SIZE'(cnt_q);
                            state_d   = S_WRITE;
                        end else begin
                            bcnt_d = bcnt_q + BC_W'(1);
                        end
                    end
                end
                S_WRITE: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == len_q) begin
                        state_d = S_RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Strobes are registered from the next state so they line up with it.
        in_ready_d = (state_d == S_HDR) || (state_d == S_LOAD);
        wr_en_d    = (state_d == S_WRITE);
        cpu_run_d  = (state_d == S_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bcnt_q     <= '0;
            asm_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            cpu_run_q  <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            asm_q      <= asm_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            cpu_run_q  <= cpu_run_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign cpu_run      = cpu_run_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected memory writes are queued as bytes are
// driven and checked when wr_en appears.
module tb_prog_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        cpu_run;
    logic        done;
    logic        err;
    logic [4:0]  words_loaded;

    typedef struct packed {
        logic [4:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  wtimes[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;

    prog_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_run      (cpu_run),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock; sample #1 after the edge and score any memory write seen.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (wr_en) begin
            wtimes.push_back(cyc);
            chk("wr_expected", 32'(exp_q.size() > 0), 32'd1);
            chk("rdy_in_write", 32'(in_ready), 32'd0);
            chk("run_in_write", 32'(cpu_run), 32'd0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e.a));
                chk("wr_data", 32'(wr_data), 32'(e.d));
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok       = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = in_ready;
            tick();
        end
        chk("byte_accept", 32'(ok), 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [15:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; in_data = 8'h00; in_valid = 1'b0;
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wr_en",    32'(wr_en), 32'd0);
        chk("rst_wr_addr",  32'(wr_addr), 32'd0);
        chk("rst_wr_data",  32'(wr_data), 32'd0);
        chk("rst_cpu_run",  32'(cpu_run), 32'd0);
        chk("rst_done",     32'(done), 32'd0);
        chk("rst_err",      32'(err), 32'd0);
        chk("rst_words",    32'(words_loaded), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", 32'(in_ready), 32'd0);

        // Normal load, in_valid held high.
        pulse_start();
        chk("hdr_in_ready", 32'(in_ready), 32'd1);
        wtimes.delete();
        expect_wr(5'd0, 16'h1234); expect_wr(5'd1, 16'hABCD); expect_wr(5'd2, 16'hF00F);
        send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAB); send_byte(8'hCD);
        send_byte(8'hF0); send_byte(8'h0F);
        chk("n_last_wr", 32'(wr_en), 32'd1);
        idle(1);
        chk("n_done",    32'(done), 32'd1);
        chk("n_cpu_run", 32'(cpu_run), 32'd1);
        chk("n_words",   32'(words_loaded), 32'd3);
        chk("n_nwrites", 32'(wtimes.size()), 32'd3);
        if (wtimes.size() == 3) begin
            chk("n_gap01", 32'(wtimes[1] - wtimes[0]), 32'd3);
            chk("n_gap12", 32'(wtimes[2] - wtimes[1]), 32'd3);
        end
        idle(1);
        chk("n_done_pulse", 32'(done), 32'd0);
        chk("n_run_hold",   32'(cpu_run), 32'd1);
        chk("n_pending",    32'(exp_q.size()), 32'd0);

        // Bad lengths: zero and 17.
        pulse_start();
        chk("b_run_drop", 32'(cpu_run), 32'd0);
        send_byte(8'h00); send_byte(8'h00);
        in_valid = 1'b0;
        chk("b0_err",     32'(err), 32'd1);
        chk("b0_cpu_run", 32'(cpu_run), 32'd0);
        chk("b0_ready",   32'(in_ready), 32'd0);
        idle(2);
        chk("b0_err_sticky", 32'(err), 32'd1);
        pulse_start();
        chk("b_err_clr", 32'(err), 32'd0);
        send_byte(8'h00); send_byte(8'h11);
        in_valid = 1'b0;
        chk("b17_err",     32'(err), 32'd1);
        chk("b17_cpu_run", 32'(cpu_run), 32'd0);
        pulse_start();
        expect_wr(5'd0, 16'h5555);
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h55); send_byte(8'h55);
        idle(1);
        chk("b_ok_err",   32'(err), 32'd0);
        chk("b_ok_run",   32'(cpu_run), 32'd1);
        chk("b_ok_words", 32'(words_loaded), 32'd1);
        chk("b_pending",  32'(exp_q.size()), 32'd0);

        // Same program with 1-0-0-1 valid pattern.
        pulse_start();
        expect_wr(5'd0, 16'h1234); expect_wr(5'd1, 16'hABCD); expect_wr(5'd2, 16'hF00F);
        send_byte(8'h00); idle(2); send_byte(8'h03); idle(2);
        send_byte(8'h12); idle(2); send_byte(8'h34); idle(2);
        send_byte(8'hAB); idle(2); send_byte(8'hCD); idle(2);
        send_byte(8'hF0); idle(2); send_byte(8'h0F); idle(2);
        chk("g_run",     32'(cpu_run), 32'd1);
        chk("g_words",   32'(words_loaded), 32'd3);
        chk("g_pending", 32'(exp_q.size()), 32'd0);

        // Abort after one data byte.
        pulse_start();
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
        in_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("a_ready", 32'(in_ready), 32'd0);
        chk("a_wr_en", 32'(wr_en), 32'd0);
        chk("a_run",   32'(cpu_run), 32'd0);
        idle(2);
        chk("a_idle_ready", 32'(in_ready), 32'd0);
        pulse_start();
        expect_wr(5'd0, 16'hAAAA); expect_wr(5'd1, 16'hBBBB);
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'hAA); send_byte(8'hAA);
        send_byte(8'hBB); send_byte(8'hBB);
        idle(1);
        chk("a_run2",    32'(cpu_run), 32'd1);
        chk("a_words",   32'(words_loaded), 32'd2);
        chk("a_pending", 32'(exp_q.size()), 32'd0);

        // Reset after three bytes of a 2-word load.
        pulse_start();
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
        #1 rst = 1'b1;
        #1;
        chk("r_ready", 32'(in_ready), 32'd0);
        chk("r_wr_en", 32'(wr_en), 32'd0);
        chk("r_run",   32'(cpu_run), 32'd0);
        chk("r_err",   32'(err), 32'd0);
        chk("r_words", 32'(words_loaded), 32'd0);
        rst = 1'b0;
        in_valid = 1'b1;
        tick(); tick(); tick();
        chk("r_no_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // Reload from RUN; start during LOAD is ignored.
        pulse_start();
        expect_wr(5'd0, 16'h1111);
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h11);
        idle(1);
        chk("l_run1", 32'(cpu_run), 32'd1);
        pulse_start();
        chk("l_run_drop", 32'(cpu_run), 32'd0);
        chk("l_hdr_rdy",  32'(in_ready), 32'd1);
        expect_wr(5'd0, 16'h2222); expect_wr(5'd1, 16'h3333);
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h22); send_byte(8'h22);
        in_valid = 1'b0;
        start = 1'b1;
        tick(); tick();
        start = 1'b0;
        send_byte(8'h33); send_byte(8'h33);
        idle(1);
        chk("l_run2",    32'(cpu_run), 32'd1);
        chk("l_words",   32'(words_loaded), 32'd2);
        chk("l_err",     32'(err), 32'd0);
        chk("l_pending", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
